// File: rtl/song_player.sv
// song_player: sequences notes from a song ROM into a tone generator, with
// per-note duration, articulation gap, pause, stop and done signalling.
module song_player #(
   parameter int UNIT_CYCLES = 6250000,
   parameter int GAP_CYCLES  = 625000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        pause,
   input  logic [2:0]  song_sel,
   input  logic [20:0] track,
   input  logic [2:0]  octave,
   input  logic [2:0]  note,
   input  logic [2:0]  full_note,
   input  logic [3:0]  length,
   output logic [2:0]  song,
   output logic [20:0] cnt,
   output logic        tone_en,
   output logic [2:0]  tone_octave,
   output logic [2:0]  tone_note,
   output logic        busy,
   output logic        done
);
   localparam longint MAXC = 256 * longint'(UNIT_CYCLES);
   localparam int TW = $clog2(MAXC + 1);
   typedef enum logic [1:0] {IDLE, FETCH, PLAY, PAUSED} state_t;
   state_t state, ret;
   logic [TW-1:0] total, elapsed, nxt, thr, dur;
   logic [2:0] fn;
   logic [8:0] units;
   logic ending, last;
   always_comb begin
      fn     = (full_note > 3'd4) ? 3'd4 : full_note;
      units  = {4'd0, 5'(length) + 5'd1} << (3'd4 - fn);
      dur    = TW'(units) * TW'(UNIT_CYCLES);
      nxt    = elapsed + TW'(1);
      thr    = total - TW'(GAP_CYCLES);
      ending = elapsed == total - TW'(1);
      last   = ({1'b0, cnt} + 22'd1) >= {1'b0, track};
   end
   assign busy = state != IDLE;
   // A cycle spent in PLAY always consumes one elapsed tick, even on the
   // cycle that enters PAUSED, so pausing never changes audible time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ret         <= IDLE;
         song        <= '0;
         cnt         <= '0;
         tone_en     <= 1'b0;
         tone_octave <= '0;
         tone_note   <= '0;
         done        <= 1'b0;
         total       <= '0;
         elapsed     <= '0;
      end else begin
         done <= 1'b0;
         if (stop && state != IDLE) begin
            state   <= IDLE;
            cnt     <= '0;
            tone_en <= 1'b0;
            elapsed <= '0;
         end else begin
            case (state)
               IDLE: if (start && !stop) begin
                  song  <= song_sel;
                  cnt   <= '0;
                  state <= FETCH;
               end
               FETCH: if (pause) begin
                  ret   <= FETCH;
                  state <= PAUSED;
               end else if (track == '0) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  tone_octave <= octave;
                  tone_note   <= note;
                  total       <= dur;
                  elapsed     <= '0;
                  tone_en     <= 1'b1;
                  state       <= PLAY;
               end
               PLAY: if (ending) begin
                  tone_en <= 1'b0;
                  elapsed <= '0;
                  if (last) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     cnt   <= cnt + 21'd1;
                     state <= FETCH;
                  end
               end else begin
                  elapsed <= nxt;
                  tone_en <= !pause && nxt < thr;
                  ret     <= PLAY;
                  state   <= pause ? PAUSED : PLAY;
               end
               PAUSED: if (!pause) begin
                  state   <= ret;
                  tone_en <= ret == PLAY && elapsed < thr;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 Parameter UNIT_CYCLES, default 6250000, clock cycles per duration unit (62.5 ms at 100 MHz).
REQ-002 Parameter GAP_CYCLES, default 625000, silent articulation cycles at the end of each note; SHALL be less than UNIT_CYCLES.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 start  in  1  one-cycle request to begin playback of song_sel.
REQ-006 stop  in  1  abort playback; level-sensitive.
REQ-007 pause  in  1  hold playback while high; level-sensitive.
REQ-008 song_sel  in  3  song index requested at start.
REQ-009 track  in  21  note count of current song, from song ROM.
REQ-010 octave, note, full_note  in  3 each  note fields from song ROM at address cnt.
REQ-011 length  in  4  note length field from song ROM.
REQ-012 song  out  3  registered song index driven to song ROM.
REQ-013 cnt  out  21  registered note address driven to song ROM.
REQ-014 tone_en  out  1  enable for downstream tone generator.
REQ-015 tone_octave, tone_note  out  3 each  registered pitch for tone generator.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on normal completion.

Function
REQ-018 FSM states: IDLE, FETCH, PLAY, PAUSED; one state register, binary or one-hot at implementer choice.
REQ-019 IDLE: on start=1, latch song<=song_sel, cnt<=0, go FETCH; start in any other state ignored.
REQ-020 FETCH (exactly 1 cycle, ROM settle): if track==0, pulse done, go IDLE; else capture tone_octave/tone_note and duration, clear timers, go PLAY.
REQ-021 Duration in units: D = (length+1) << (4 - min(full_note,4)); full_note>4 treated as 4; range 1..256 units.
REQ-022 Duration arithmetic: D*UNIT_CYCLES held in a counter wide enough for 256*UNIT_CYCLES without overflow.
REQ-023 PLAY: elapsed counter increments each cycle; tone_en=1 while elapsed < D*UNIT_CYCLES - GAP_CYCLES, else 0.
REQ-024 PLAY end: when elapsed reaches D*UNIT_CYCLES-1, if cnt==track-1 pulse done and go IDLE; else cnt<=cnt+1 and go FETCH.
REQ-025 Latency: tone_en rises 2 cycles after start (IDLE->FETCH->PLAY); gap between notes is GAP_CYCLES+1 silent cycles.
REQ-026 PAUSED: entered from PLAY or FETCH when pause=1; elapsed, cnt, song frozen; tone_en=0; return to the exact originating state when pause=0.
REQ-027 stop=1 in any non-IDLE state: next cycle IDLE, tone_en=0, cnt<=0, no done pulse; stop has priority over pause and completion.
REQ-028 stop and start same cycle in IDLE: stay IDLE.
REQ-029 track treated as unsigned; cnt never exceeds track-1; track changing mid-song takes effect at next comparison.
REQ-030 done asserted only in the cycle following the final note end or zero-track FETCH.

Reset
REQ-031 rst_n=0 forces asynchronously: state IDLE, song=0, cnt=0, tone_en=0, tone_octave=0, tone_note=0, busy=0, done=0, all timers 0.
REQ-032 Reset mid-playback aborts without done pulse; first start after release plays from cnt=0.

Verification (UNIT_CYCLES=8, GAP_CYCLES=2)
REQ-033 Two-note song (track=2, length=0, full_note=4): start -> tone_en high 6 cycles, low 2, cnt 0->1, second note likewise, done pulse once, busy falls; total 2+16 cycles.
REQ-034 length=3, full_note=2: single note lasts 16 units = 128 cycles, tone_en high 126 cycles.
REQ-035 pause high 20 cycles mid-note -> tone_en low, cnt/elapsed frozen, note completes 20 cycles late with total audible time unchanged.
REQ-036 stop during note 1 of 3 -> IDLE next cycle, cnt=0, no done; track=0 start -> done 2 cycles after start, tone_en never high.
REQ-037 rst_n low during PLAY -> all outputs zero immediately (asynchronous, before next clk edge); start ignored while busy keeps cnt sequence intact.
